// File: rtl/mips_pkg.sv
// Shared MIPS multicycle controller constants: FSM state codes, opcodes, funct codes, ALU codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCHEX = 4'd8,
    IMMEX    = 4'd9,
    IMMWB    = 4'd10,
    JEX      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mc_aludec.sv
// ALU function and immediate-extension select, decoded from FSM state, opcode and funct.
module mc_aludec
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       sextend,
  output logic       funct_ok
);

  always_comb begin
    alucontrol = ALU_AND;
    sextend    = 1'b0;
    funct_ok   = 1'b0;
    case (state_t'(state))
      FETCH: alucontrol = ALU_ADD;
      DECODE, MEMADR: begin
        alucontrol = ALU_ADD;
        sextend    = 1'b1;
      end
      RTYPEEX: begin
        funct_ok = 1'b1;
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_ok   = 1'b0;
        endcase
      end
      BRANCHEX: alucontrol = ALU_SUB;
      IMMEX: begin
        case (op)
          OP_ADDI: begin alucontrol = ALU_ADD; sextend = 1'b1; end
          OP_SLTI: begin alucontrol = ALU_SLT; sextend = 1'b1; end
          OP_ANDI: alucontrol = ALU_AND;
          OP_ORI:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory-wait timeout.
// Define MC_BNE_EN to decode bne as a branch; otherwise bne is an illegal opcode.
module mc_controller
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memreq,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       sextend,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       err,
  output logic [3:0] state
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     cur, nxt;
  logic [7:0] wcnt;
  logic       waiting, tmo, illegal_op, funct_ok, br_take;

  mc_aludec u_aludec (
    .state      (cur),
    .op         (op),
    .funct      (funct),
    .alucontrol (alucontrol),
    .sextend    (sextend),
    .funct_ok   (funct_ok)
  );

  assign waiting = ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR)) && !mem_ready;
  assign tmo     = (TIMEOUT != 0) && waiting && (wcnt == TMO_LAST);

`ifdef MC_BNE_EN
  assign br_take = (op == OP_BNE) ? !zero : zero;
`else
  assign br_take = zero;
`endif

  always_comb begin
    nxt        = FETCH;
    illegal_op = 1'b0;
    case (cur)
      FETCH: nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                      nxt = MEMADR;
          OP_RTYPE:                          nxt = RTYPEEX;
          OP_BEQ:                            nxt = BRANCHEX;
`ifdef MC_BNE_EN
          OP_BNE:                            nxt = BRANCHEX;
`endif
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = IMMEX;
          OP_J:                              nxt = JEX;
          default:                           illegal_op = 1'b1;
        endcase
      end
      MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      RTYPEEX: nxt = funct_ok ? RTYPEWB : FETCH;
      IMMEX:   nxt = IMMWB;
      default: nxt = FETCH;
    endcase
    if (tmo) nxt = FETCH;
  end

  // A timeout in FETCH keeps the state unchanged, so it must clear the counter explicitly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= FETCH;
      wcnt <= '0;
    end else begin
      cur <= nxt;
      if (tmo || (nxt != cur)) wcnt <= '0;
      else if (waiting)        wcnt <= wcnt + 8'd1;
    end
  end

  always_comb begin
    memreq   = 1'b0;
    pcen     = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    case (cur)
      FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord   = 1'b1;
        memreq = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memreq   = 1'b1;
        memwrite = !tmo;
      end
      RTYPEEX: alusrca = 1'b1;
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCHEX: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        pcen    = br_take;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      IMMWB: regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign err   = reset && (illegal_op || ((cur == RTYPEEX) && !funct_ok) || tmo);
  assign state = cur;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
- REQ-001 SHALL have parameter TIMEOUT, default 255; maximum memory-wait cycles before abort (0 = no timeout).
- REQ-002 SHALL have port clk  in  1  single clock, rising edge.
- REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
- REQ-004 SHALL have ports op  in  6  and funct  in  6  from the instruction register, stable from DECODE until return to FETCH.
- REQ-005 SHALL have port zero  in  1  ALU zero flag.
- REQ-006 SHALL have port mem_ready  in  1  memory transfer completes this cycle.
- REQ-007 SHALL have port memreq  out  1  memory access requested.
- REQ-008 SHALL have ports pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, sextend  out  1 each  datapath enables and mux selects.
- REQ-009 SHALL have ports alusrcb  out  2, pcsrc  out  2, alucontrol  out  4  ALU operand, PC source and ALU function selects.
- REQ-010 SHALL have port err  out  1  one-cycle pulse on illegal opcode or timeout.
- REQ-011 SHALL have port state  out  4  current FSM state, for debug.

Function
- REQ-012 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BRANCHEX=8, IMMEX=9, IMMWB=10, JEX=11; codes 12-15 SHALL go to FETCH.
- REQ-013 Outputs not listed for a state SHALL be 0.
- REQ-014 FETCH: memreq=1, alusrcb=01, alucontrol=ADD. irwrite=1 and pcen=1 only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
- REQ-015 DECODE: alusrcb=11, alucontrol=ADD, sextend=1. Next state by op: lw/sw (100011/101011)->MEMADR; R-type (000000)->RTYPEEX; beq (000100)->BRANCHEX; addi/slti (001000/001010) and andi/ori (001100/001101)->IMMEX; j (000010)->JEX; any other op->FETCH with err=1.
- REQ-016 MEMADR: alusrca=1, alusrcb=10, ADD, sextend=1. Next is MEMRD for lw and MEMWR for sw.
- REQ-017 MEMRD: iord=1, memreq=1; go to MEMWB on mem_ready. MEMWB: memtoreg=1, regwrite=1; then FETCH.
- REQ-018 MEMWR: iord=1, memreq=1, memwrite=1; go to FETCH on mem_ready.
- REQ-019 RTYPEEX: alusrca=1, alusrcb=00. alucontrol by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct SHALL raise err and go to FETCH; otherwise go to RTYPEWB.
- REQ-020 RTYPEWB: regdst=1, regwrite=1; then FETCH.
- REQ-021 BRANCHEX: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero (combinational on zero); then FETCH.
- REQ-022 IMMEX: alusrca=1, alusrcb=10. addi->ADD with sextend=1; slti->SLT with sextend=1; andi->AND with sextend=0; ori->OR with sextend=0. Then IMMWB.
- REQ-023 IMMWB: regwrite=1, regdst=0, memtoreg=0; then FETCH.
- REQ-024 JEX: pcsrc=10, pcen=1; then FETCH.
- REQ-025 An 8-bit wait counter SHALL increment in each FETCH, MEMRD or MEMWR cycle with mem_ready=0, and clear on any state change.
- REQ-026 If TIMEOUT!=0 and the counter equals TIMEOUT-1 while mem_ready=0, the FSM SHALL pulse err, go to FETCH, and assert no write enables.
- REQ-027 mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.

Reset
- REQ-028 While reset=0, the state SHALL be FETCH, the wait counter 0 and err 0, asynchronously. After release, the first rising edge SHALL evaluate FETCH normally.
- REQ-029 Reset asserted mid-instruction SHALL abort it. No write enable SHALL assert while reset=0 except the FETCH-defined ones, which are gated by mem_ready.

Configuration
- REQ-030 With MC_BNE_EN defined, bne (000101) SHALL decode to BRANCHEX with pcen=~zero; without it, bne SHALL be illegal (err, FETCH).

Structure
- REQ-031 The state codes, opcode/funct constants and ALU codes (AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111) SHALL live in shared package mips_pkg.
- REQ-032 ALU decode (op/funct/state -> alucontrol, sextend) SHALL be sub-module mc_aludec; next-state, counter and outputs SHALL be in mc_controller.

Verification
- REQ-033 lw, op=100011, mem_ready=1 every cycle -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
- REQ-034 beq with zero=1 -> pcen=1, pcsrc=01 in BRANCHEX; with zero=0 -> pcen=0.
- REQ-035 FETCH with mem_ready held 0, TIMEOUT=4 -> err pulses after 4 cycles, irwrite is never 1, state stays 0.
- REQ-036 op=111111 -> err=1 in DECODE, next state FETCH, no regwrite/memwrite.
- REQ-037 ori, op=001101 -> IMMEX with alucontrol=0001, sextend=0; IMMWB with regwrite=1.
- REQ-038 reset driven low during MEMWR -> state=0 immediately and memwrite=0.
